uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial UART receiver that feeds the debug unit's command and instruction-load path.
- Oversamples the RX line at 16x baud, validates the start and stop bits, and assembles LSB-first data bytes.
- Presents each byte with a sticky "data received" level that the debug unit clears through its rx-reset/clear output.
- Contains a baud-tick generator sub-module and a 2-flop input synchronizer.

Parameters:
DATA_BITS, 8, data bits per frame.
OVERSAMPLE, 16, ticks per bit period.
STOP_TICKS, 16, ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5 stop bits, 32 = 2 stop bits).
BAUD_DIV, 163, clock cycles per oversample tick (50 MHz / (19200*16), rounded).

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous reset, active-low (asserted when 0)
i_rx  in  1  asynchronous serial line, idle high
i_rx_clear  in  1  active-high clear of o_data_received, o_frame_err, o_overrun
o_data  out  DATA_BITS  last valid received byte
o_data_received  out  1  sticky: a valid byte is held in o_data
o_frame_err  out  1  sticky: last frame had stop bit = 0
o_overrun  out  1  sticky: a byte completed while o_data_received was still 1

Behaviour:
- One clock, i_clk. Reset is synchronous and active-low: i_rst==0 at a rising edge resets the block.
- Reset values:
  - state=IDLE; tick and bit counters 0; shift register 0; synchronizer flops 1.
  - o_data=0; o_data_received=0; o_frame_err=0; o_overrun=0.
  - Baud counter 0.
- Synchronizer: i_rx passes through 2 flops. The FSM uses only the synchronized value, rx_s.
- Baud generator:
  - Free-running counter 0..BAUD_DIV-1, width $clog2(BAUD_DIV).
  - tick is high for exactly one cycle when count==BAUD_DIV-1, then the counter wraps to 0.
  - The counter is never restarted by frame activity.
- FSM (states IDLE, START, DATA, STOP; tick counter s 0..max(OVERSAMPLE,STOP_TICKS)-1; bit counter n 0..DATA_BITS-1):
  - IDLE: when rx_s==0, go to START with s=0. No tick is required.
  - START: on tick, if s==OVERSAMPLE/2-1 (mid start bit):
    - rx_s==0: go to DATA with s=0, n=0.
    - rx_s==1: glitch. Return to IDLE with no flag change.
    - Otherwise s++.
  - DATA: on tick, if s==OVERSAMPLE-1:
    - Shift right with rx_s entering the MSB (LSB-first frame); s=0.
    - If n==DATA_BITS-1, go to STOP; else n++.
    - Otherwise s++.
  - STOP: on tick, if s==STOP_TICKS-1:
    - rx_s==1: o_data<=shift register; o_data_received<=1; o_frame_err<=0.
    - rx_s==0: o_frame_err<=1; o_data and o_data_received unchanged.
    - Go to IDLE in both cases. Otherwise s++.
- Latency: o_data_received rises 1 clock after the tick that samples the stop bit. It is registered, with no combinational path from i_rx.
- Overrun: on a valid completion while o_data_received==1 and i_rx_clear==0:
  - o_overrun<=1 and o_data is overwritten with the new byte.
- Clear: i_rx_clear==1 zeroes o_data_received, o_frame_err and o_overrun.
  - It does not abort a frame in progress and does not touch o_data.
  - Holding clear high keeps the flags low.
- Clear in the same cycle as a completion: the completion wins.
  - o_data_received=1 and o_data=new byte.
  - o_overrun and o_frame_err are set only from this frame's result.
- Reset mid-frame: the FSM returns to IDLE and the partial byte is discarded. The receiver resynchronizes on the next falling edge.
- Line stuck low after a frame error: IDLE re-enters START immediately. Each 0-byte with stop=0 re-flags o_frame_err. No lock-up.
- All counter arithmetic is unsigned modulo register width. n never exceeds DATA_BITS-1.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11).
  - Default BAUD_DIV and OVERSAMPLE constants, reused by the uart_tx counterpart.
- One sub-module: baud_rate_gen (params BAUD_DIV; ports i_clk, i_rst, o_tick), shared with the transmitter.

Test Plan:
- BAUD_DIV=4. Send frame 0x72 ('r') at 64 clk/bit -> o_data=0x72, o_data_received=1 one clk after the stop sample tick; o_frame_err=0; o_overrun=0.
- Pulse i_rx low for 3 ticks only -> FSM returns to IDLE; o_data_received stays 0; then frame 0x73 -> o_data=0x73.
- Send 0xA5 with stop bit driven 0 -> o_frame_err=1; o_data_received=0; o_data unchanged; next pulse of i_rx_clear -> o_frame_err=0.
- Send 0x73 then 0x6E with no clear -> o_data=0x6E, o_overrun=1; assert i_rx_clear for 1 clk -> all three flags 0, o_data=0x6E.
- Assert i_rx_clear exactly in the completion cycle of 0x6C -> o_data_received=1, o_data=0x6C, o_overrun=0.
- Drive i_rst=0 for 2 clks during DATA bit 3 of 0xFF -> all outputs 0, state IDLE; then frame 0x6C -> o_data=0x6C received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings, default timing constants
// and counter-width helpers used by the receiver, transmitter and baud generator.
package uart_rx_pkg;

  // Receiver FSM encodings (explicit so waveforms match the legacy design)
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_t;

  // 50 MHz / (19200 * 16), rounded
  localparam int unsigned DEFAULT_BAUD_DIV   = 163;
  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  // Width of a counter that must hold 0..n-1 (never narrower than one bit)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/baud_rate_gen.sv
// Free-running oversample tick generator: one-cycle o_tick every BAUD_DIV clocks.
// Never restarted by line activity, so RX and TX share the same phase.
module baud_rate_gen
  import uart_rx_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int unsigned CNT_W = cnt_width(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_tick;

  assign w_tick = (r_count == CNT_LAST);
  assign o_tick = w_tick;

  // Count 0..BAUD_DIV-1 and wrap on the tick cycle
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_count <= '0;
    end else if (w_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver for the debug command path: 16x oversampled, LSB-first,
// start/stop validation, sticky received / frame-error / overrun flags.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int unsigned STOP_TICKS = 16,
  parameter int unsigned BAUD_DIV   = DEFAULT_BAUD_DIV
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  input  logic                 i_rx_clear,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_data_received,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int unsigned S_W = cnt_width(max_u(OVERSAMPLE, STOP_TICKS));
  localparam int unsigned N_W = cnt_width(DATA_BITS);

  localparam logic [S_W-1:0] S_MID       = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(STOP_TICKS - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DATA_BITS - 1);

  // Input synchronizer
  logic r_rx_meta;
  logic r_rx_sync;
  logic w_rx_s;

  // Receive FSM state and datapath
  rx_state_t            r_state;
  rx_state_t            w_state_next;
  logic [S_W-1:0]       r_s;
  logic [S_W-1:0]       w_s_next;
  logic [N_W-1:0]       r_n;
  logic [N_W-1:0]       w_n_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic                 w_done_ok;
  logic                 w_done_bad;

  // Output registers
  logic [DATA_BITS-1:0] r_data;
  logic                 r_data_received;
  logic                 r_frame_err;
  logic                 r_overrun;

  logic w_tick;

  baud_rate_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (w_tick)
  );

  assign w_rx_s = r_rx_sync;

  // Two-flop synchronizer for the asynchronous line (idles high)
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // FSM state, tick/bit counters and shift register
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_s     <= w_s_next;
      r_n     <= w_n_next;
      r_shift <= w_shift_next;
    end
  end

  // Next-state, counter and completion decode
  always_comb begin
    w_state_next = r_state;
    w_s_next     = r_s;
    w_n_next     = r_n;
    w_shift_next = r_shift;
    w_done_ok    = 1'b0;
    w_done_bad   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_next = START;
          w_s_next     = '0;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_s == S_MID) begin
            if (!w_rx_s) begin
              w_state_next = DATA;
              w_s_next     = '0;
              w_n_next     = '0;
            end else begin
              w_state_next = IDLE;
              w_s_next     = '0;
            end
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_s == S_BIT_LAST) begin
            w_shift_next = {w_rx_s, r_shift[DATA_BITS-1:1]};
            w_s_next     = '0;
            if (r_n == N_LAST) begin
              w_state_next = STOP;
            end else begin
              w_n_next = r_n + 1'b1;
            end
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_s == S_STOP_LAST) begin
            w_done_ok    = w_rx_s;
            w_done_bad   = !w_rx_s;
            w_state_next = IDLE;
            w_s_next     = '0;
          end else begin
            w_s_next = r_s + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_s_next     = '0;
        w_n_next     = '0;
      end
    endcase
  end

  // Sticky flags and data holding register; a completion outranks a
  // same-cycle clear, but the clear still wipes history from earlier frames.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_data          <= '0;
      r_data_received <= 1'b0;
      r_frame_err     <= 1'b0;
      r_overrun       <= 1'b0;
    end else if (w_done_ok) begin
      r_data          <= r_shift;
      r_data_received <= 1'b1;
      r_frame_err     <= 1'b0;
      r_overrun       <= i_rx_clear ? r_data_received & 1'b0 : (r_overrun | r_data_received);
    end else if (w_done_bad) begin
      r_frame_err <= 1'b1;
      if (i_rx_clear) begin
        r_data_received <= 1'b0;
        r_overrun       <= 1'b0;
      end
    end else if (i_rx_clear) begin
      r_data_received <= 1'b0;
      r_frame_err     <= 1'b0;
      r_overrun       <= 1'b0;
    end
  end

  assign o_data          = r_data;
  assign o_data_received = r_data_received;
  assign o_frame_err     = r_frame_err;
  assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_DIV=4 (64 clocks per bit) with a
// byte scoreboard fed by the frame driver and drained by an output monitor.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int unsigned BIT_CLKS = 64;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_rx_clear = 1'b0;
  logic [7:0] o_data;
  logic       o_data_received;
  logic       o_frame_err;
  logic       o_overrun;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       prev_dr = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       seen;

  always #5 i_clk = ~i_clk;

  uart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .STOP_TICKS (16),
    .BAUD_DIV   (4)
  ) dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_rx            (i_rx),
    .i_rx_clear      (i_rx_clear),
    .o_data          (o_data),
    .o_data_received (o_data_received),
    .o_frame_err     (o_frame_err),
    .o_overrun       (o_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one frame; a bad stop bit is held low long enough to be sampled,
  // then released so the FSM's immediate re-entry into START reads a glitch.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    @(negedge i_clk);
    i_rx = 1'b0;
    repeat (BIT_CLKS) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (BIT_CLKS) @(negedge i_clk);
    end
    if (stop_ok) begin
      i_rx = 1'b1;
      repeat (BIT_CLKS) @(negedge i_clk);
    end else begin
      i_rx = 1'b0;
      repeat (48) @(negedge i_clk);
      i_rx = 1'b1;
      repeat (BIT_CLKS) @(negedge i_clk);
    end
  endtask

  task automatic pulse_clear();
    @(negedge i_clk);
    i_rx_clear = 1'b1;
    @(negedge i_clk);
    i_rx_clear = 1'b0;
  endtask

  // Output monitor: every newly presented byte must match the next expected one
  always @(negedge i_clk) begin
    if (i_rst === 1'b1 && o_data_received === 1'b1 &&
        (prev_dr !== 1'b1 || o_data !== prev_data)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_unexpected observed %0h expected none", o_data);
      end else begin
        check("scoreboard_byte", {24'h0, o_data}, {24'h0, exp_q.pop_front()});
      end
    end
    prev_dr   <= o_data_received;
    prev_data <= o_data;
  end

  initial begin
    // Reset
    repeat (4) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("rst_data", o_data, 0);
    check("rst_dr", o_data_received, 0);
    check("rst_ferr", o_frame_err, 0);
    check("rst_ovr", o_overrun, 0);
    check("rst_state", dut.r_state, IDLE);
    repeat (20) @(negedge i_clk);

    // Basic frame 'r'
    exp_q.push_back(8'h72);
    send_frame(8'h72, 1'b1);
    check("t1_data", o_data, 8'h72);
    check("t1_dr", o_data_received, 1);
    check("t1_ferr", o_frame_err, 0);
    check("t1_ovr", o_overrun, 0);
    pulse_clear();
    check("t1_clr_dr", o_data_received, 0);
    check("t1_clr_data", o_data, 8'h72);

    // Short glitch on the line is rejected
    @(negedge i_clk);
    i_rx = 1'b0;
    repeat (12) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge i_clk);
    check("t2_glitch_dr", o_data_received, 0);
    check("t2_glitch_ferr", o_frame_err, 0);
    check("t2_glitch_state", dut.r_state, IDLE);
    exp_q.push_back(8'h73);
    send_frame(8'h73, 1'b1);
    check("t2_data", o_data, 8'h73);
    pulse_clear();

    // Frame error: stop bit low
    send_frame(8'hA5, 1'b0);
    check("t3_ferr", o_frame_err, 1);
    check("t3_dr", o_data_received, 0);
    check("t3_data", o_data, 8'h73);
    pulse_clear();
    check("t3_clr_ferr", o_frame_err, 0);

    // Overrun: two bytes without a clear
    exp_q.push_back(8'h73);
    send_frame(8'h73, 1'b1);
    check("t4_first_ovr", o_overrun, 0);
    exp_q.push_back(8'h6E);
    send_frame(8'h6E, 1'b1);
    check("t4_data", o_data, 8'h6E);
    check("t4_ovr", o_overrun, 1);
    check("t4_dr", o_data_received, 1);
    pulse_clear();
    check("t4_clr_dr", o_data_received, 0);
    check("t4_clr_ferr", o_frame_err, 0);
    check("t4_clr_ovr", o_overrun, 0);
    check("t4_clr_data", o_data, 8'h6E);

    // Clear held until the completion edge, dropped right after it
    exp_q.push_back(8'h6C);
    seen = 1'b0;
    fork
      send_frame(8'h6C, 1'b1);
      begin
        i_rx_clear = 1'b1;
        for (int k = 0; k < 2000 && !seen; k++) begin
          @(posedge i_clk);
          #1;
          if (o_data_received === 1'b1) seen = 1'b1;
        end
        i_rx_clear = 1'b0;
      end
    join
    check("t5_completion_seen", seen, 1);
    check("t5_dr", o_data_received, 1);
    check("t5_data", o_data, 8'h6C);
    check("t5_ovr", o_overrun, 0);
    check("t5_ferr", o_frame_err, 0);

    // Reset during data bit 3 of 0xFF
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (4 * BIT_CLKS + 32) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        check("t6_rst_state", dut.r_state, IDLE);
      end
    join
    check("t6_data", o_data, 0);
    check("t6_dr", o_data_received, 0);
    check("t6_ferr", o_frame_err, 0);
    check("t6_ovr", o_overrun, 0);
    check("t6_state", dut.r_state, IDLE);
    exp_q.push_back(8'h6C);
    send_frame(8'h6C, 1'b1);
    check("t6_after_data", o_data, 8'h6C);
    check("t6_after_dr", o_data_received, 1);

    repeat (BIT_CLKS) @(negedge i_clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
